// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the sequential integer square-root engine.
// The width-check macro guards every instantiation against odd or tiny radicand widths.
`ifndef SQRT_PKG_MACROS
`define SQRT_PKG_MACROS
`define SQRT_CHECK_EVEN_W(w_) \
    if ((((w_) % 2) != 0) || ((w_) < 4)) begin : g_bad_w \
        $error("isqrt_seq: W must be even and >= 4"); \
    end
`endif

package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int iter_w(input int w);
        return w / 2;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// One digit-by-digit square-root iteration: consumes two radicand bits and
// produces one root bit. Purely combinational.
module isqrt_step #(
    parameter int N = 8
) (
    input  logic [N+1:0] p,
    input  logic [N-1:0] r,
    input  logic [1:0]   a_top,
    output logic [N+1:0] p_next,
    output logic [N-1:0] r_next
);

    logic [N+1:0] p_sh;
    logic [N+1:0] trial;
    logic         ge;

    // The bits shifted out of p are always zero, since the partial remainder never exceeds 2*R.
    always_comb begin
        p_sh   = (p << 2) | {{N{1'b0}}, a_top};
        trial  = ({2'b00, r} << 2) | {{(N+1){1'b0}}, 1'b1};
        ge     = (p_sh >= trial);
        p_next = ge ? (p_sh - trial) : p_sh;
        r_next = (r << 1) | {{(N-1){1'b0}}, ge};
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: floor(sqrt(radicand)) and remainder,
// one root bit per cycle, with a start/done handshake.
module isqrt_seq
    import sqrt_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             rst_ld,
    input  logic             start,
    input  logic [W-1:0]     radicand,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [W/2-1:0]   root,
    output logic [W/2:0]     remainder
);

    localparam int N  = iter_w(W);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    `SQRT_CHECK_EVEN_W(W)

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a;
    logic [N-1:0]  r;
    logic [N-1:0]  r_nxt;
    logic [N+1:0]  p;
    logic [N+1:0]  p_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;

    isqrt_step #(.N(N)) u_step (
        .p      (p),
        .r      (r),
        .a_top  (a[W-1:W-2]),
        .p_next (p_nxt),
        .r_next (r_nxt)
    );

    assign accept = ready && start;
    assign last   = (state == RUN) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst_ld) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE) || (state == DONE);
        busy  = (state == RUN);
        done  = (state == DONE);
    end

    // Results are latched only on the final iteration so intermediate roots never leak out.
    always_ff @(posedge clk) begin
        if (rst_ld) begin
            a         <= '0;
            r         <= '0;
            p         <= '0;
            cnt       <= '0;
            root      <= '0;
            remainder <= '0;
        end else if (accept) begin
            a   <= radicand;
            r   <= '0;
            p   <= '0;
            cnt <= CW'(N - 1);
        end else if (state == RUN) begin
            a <= a << 2;
            r <= r_nxt;
            p <= p_nxt;
            if (cnt == '0) begin
                root      <= r_nxt;
                remainder <= p_nxt[N:0];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_isqrt_seq.sv
// Directed and randomized checks of isqrt_seq at W=16 and W=8 against an
// arithmetic reference (largest r with r*r <= x).
module tb_isqrt_seq;

    logic        clk = 1'b0;
    logic        rst_ld;
    logic        start16, start8;
    logic [15:0] rad16;
    logic [7:0]  rad8;
    logic        ready16, busy16, done16;
    logic        ready8, busy8, done8;
    logic [7:0]  root16;
    logic [8:0]  rem16;
    logic [3:0]  root8;
    logic [4:0]  rem8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    isqrt_seq #(.W(16)) dut16 (
        .clk(clk), .rst_ld(rst_ld), .start(start16), .radicand(rad16),
        .ready(ready16), .busy(busy16), .done(done16),
        .root(root16), .remainder(rem16)
    );

    isqrt_seq #(.W(8)) dut8 (
        .clk(clk), .rst_ld(rst_ld), .start(start8), .radicand(rad8),
        .ready(ready8), .busy(busy8), .done(done8),
        .root(root8), .remainder(rem8)
    );

    function automatic int ref_root(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept x at the next edge, then wait (bounded) for done; returns edges
    // from accept to done and how many sampled cycles showed busy.
    task automatic go16(input int x, output int lat, output int bcnt);
        start16 = 1'b1;
        rad16   = x[15:0];
        step();
        start16 = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!done16 && lat < 40) begin
            if (busy16) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic go8(input int x, output int lat);
        start8 = 1'b1;
        rad8   = x[7:0];
        step();
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic check16(input string tag, input int x);
        chk({tag, "_root"}, int'(root16), ref_root(x));
        chk({tag, "_rem"},  int'(rem16),  x - ref_root(x) * ref_root(x));
    endtask

    initial begin
        int lat, bcnt, lat2, c1, pulses, x;

        rst_ld = 1'b1;
        start16 = 1'b0; start8 = 1'b0;
        rad16 = '0; rad8 = '0;
        step(); step();
        rst_ld = 1'b0;
        step();

        chk("rst_ready", int'(ready16), 1);
        chk("rst_busy",  int'(busy16),  0);
        chk("rst_done",  int'(done16),  0);
        chk("rst_root",  int'(root16),  0);
        chk("rst_rem",   int'(rem16),   0);

        // 144: latency, busy span, single-cycle done
        go16(144, lat, bcnt);
        chk("lat_144", lat, 8);
        chk("busy_144", bcnt, 8);
        chk("root_144", int'(root16), 12);
        chk("rem_144", int'(rem16), 0);
        step();
        chk("done_pulse_144", int'(done16), 0);
        chk("idle_ready", int'(ready16), 1);

        go16(16'hFFFF, lat, bcnt);
        chk("root_ffff", int'(root16), 255);
        chk("rem_ffff", int'(rem16), 510);
        step();
        go16(0, lat, bcnt);
        chk("lat_zero", lat, 8);
        chk("root_zero", int'(root16), 0);
        chk("rem_zero", int'(rem16), 0);
        step();

        // Back-to-back: restart during the DONE cycle
        go16(145, lat, bcnt);
        c1 = cyc;
        chk("root_145", int'(root16), 12);
        chk("rem_145", int'(rem16), 1);
        go16(99, lat2, bcnt);
        chk("root_99", int'(root16), 9);
        chk("rem_99", int'(rem16), 18);
        chk("b2b_gap", cyc - c1, 9);
        step();

        // Start during RUN must be ignored
        start16 = 1'b1; rad16 = 16'd200;
        step();
        start16 = 1'b0;
        step(); step();
        start16 = 1'b1; rad16 = 16'd50000;
        step();
        start16 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done16) pulses++;
            step();
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_root", int'(root16), 14);
        chk("ign_rem", int'(rem16), 4);

        // Reset mid-RUN
        start16 = 1'b1; rad16 = 16'd1000;
        step();
        start16 = 1'b0;
        step(); step(); step();
        rst_ld = 1'b1;
        step();
        rst_ld = 1'b0;
        chk("rstrun_ready", int'(ready16), 1);
        chk("rstrun_busy", int'(busy16), 0);
        chk("rstrun_root", int'(root16), 0);
        chk("rstrun_rem", int'(rem16), 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done16) pulses++;
            step();
        end
        chk("rstrun_nodone", pulses, 0);
        go16(1000, lat, bcnt);
        chk("root_1000", int'(root16), 31);
        chk("rem_1000", int'(rem16), 39);
        step();

        // Random radicands, alternating back-to-back and idle gaps
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(65535, 0));
            go16(x, lat, bcnt);
            chk("rnd_lat", lat, 8);
            check16("rnd", x);
            if (i % 2 == 0) step();
        end

        // W=8 instance: explicit case then exhaustive sweep
        go8(200, lat);
        chk("w8_lat_200", lat, 4);
        chk("w8_root_200", int'(root8), 14);
        chk("w8_rem_200", int'(rem8), 4);
        for (int v = 0; v < 256; v++) begin
            go8(v, lat);
            chk("w8_lat", lat, 4);
            chk("w8_root", int'(root8), ref_root(v));
            chk("w8_rem", int'(rem8), v - ref_root(v) * ref_root(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isqrt_seq.md
Name: isqrt_seq

Overview:
Parametrised sequential integer square-root engine that generalises the fixed 16-bit A/R shift-register pair into a complete unit. It covers the operand shift register, root and remainder registers, an iteration counter and a start/done handshake. It computes floor(sqrt(radicand)) and the remainder using the digit-by-digit (2 bits per cycle) method. It sits behind the top-level control as the datapath-plus-FSM for the square-root path.

Parameters:
W, 16, radicand width in bits; must be even and >= 4 (elaboration error otherwise)
N, W/2, derived (localparam): iteration count and root width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_ld  input  1  synchronous active-high reset
start  input  1  request; sampled only when ready=1
radicand  input  W  operand; captured on the accepted-start edge only
ready  output  1  high in IDLE and DONE (start will be accepted)
busy  output  1  high in RUN
done  output  1  one-cycle pulse, results valid
root  output  N  floor(sqrt(radicand)), held until next completion
remainder  output  N+1  radicand - root*root, held until next completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst_ld is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, root=0, remainder=0. Internal A, R (working root), P (partial remainder) and cnt are all 0.
- Reset mid-RUN: the computation is abandoned, no done pulse, and outputs read 0 on the next cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge E0: A<=radicand, R<=0, P<=0, cnt<=N-1, state<=RUN.
- DONE with start=0: state<=IDLE.
- RUN, one iteration per edge:
  - Form P' = (P<<2) | A[W-1:W-2], width N+2.
  - Form T = (R<<2) | 1, width N+2.
  - If P' >= T (unsigned): P<=P'-T, R<=(R<<1)|1.
  - Otherwise: P<=P', R<=R<<1.
  - Always A<=A<<2.
- RUN, on the edge where cnt==0: perform the final iteration, latch root<=R_next and remainder<=P_next[N:0], state<=DONE. Otherwise cnt<=cnt-1.
- Latency: with start accepted at edge E0, done is high for the single cycle following edge E0+N (N=8 edges later for W=16). root/remainder update at that same edge.
- Back-to-back: start=1 during the DONE cycle is accepted, so done is one cycle and the next RUN begins immediately. Throughput is one result per N+1 cycles.
- start while busy=1 is ignored; radicand changes during RUN have no effect.
- root/remainder never show intermediate values. They change only at completion or reset.
- Width rules: the remainder is at most 2*root, so N+1 bits always suffice. Internal compare/subtract is N+2 bits. There is no overflow case.
- radicand=0 completes normally: root=0, remainder=0, done pulses.

Decomposition:
- Package sqrt_pkg:
  - state enum {IDLE, RUN, DONE}, 2 bits
  - function iter_w(W) returning W/2
  - elaboration check macro for even W
- Sub-module isqrt_step: purely combinational, one digit iteration.
  - Inputs: P, R, top 2 bits of A.
  - Outputs: P_next, R_next.
  - Parametrised on N, instantiated once.
- The top module keeps the FSM, counter and registers.

Test Plan:
- W=16, radicand=144, start one cycle -> done pulses exactly 8 edges after accept; root=12, remainder=0; busy high 8 cycles.
- W=16, radicand=16'hFFFF -> root=255, remainder=510. Then radicand=0 -> root=0, remainder=0, with a normal done pulse.
- W=16, radicand=145 then, with start held high in the DONE cycle, radicand=99 -> first result 12/1; second result 9/18; second done 9 cycles after first.
- W=16, start=1 and radicand=50000 asserted on cycle 3 of RUN for radicand=200 -> ignored; result 14/4; only one done pulse.
- W=16, rst_ld at cycle 4 of RUN for radicand=1000 -> no done; root=0, remainder=0, ready=1 next cycle. A new start for 1000 -> 31/39.
- W=8 instance, radicand=200 -> root=14, remainder=4, done 4 edges after accept. Exhaustive sweep 0..255 against the reference model: every result matches.
